// File: rtl/reconfig_cache_ctrl.sv
// Run-time reconfigurable set-associative cache controller, write-through, no write-allocate.
// Optional hit/miss statistics counters are built in when CACHE_STATS_EN is defined.
module reconfig_cache_ctrl #(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int NUM_WAYS = 4,
   parameter int DEPTH    = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [1:0]        selection_signal,
   input  logic              i_read,
   input  logic              i_write,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [DATA_W-1:0] i_writedata,
   output logic              o_ready,
   output logic [DATA_W-1:0] o_readdata,
   output logic              o_readdata_valid,
   output logic              hit,
   output logic              miss,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [31:0]       hit_count,
   output logic [31:0]       miss_count
);
   localparam int IDX_W = $clog2(DEPTH);
   localparam int WAY_W = $clog2(NUM_WAYS);
   localparam int WA_W  = ADDR_W - 2;
   localparam int TAG_W = WA_W - IDX_W;

   typedef enum logic [2:0] {S_IDLE, S_FLUSH, S_COMPARE, S_MEM_RD, S_MEM_WR} state_t;
   state_t r_state, w_state_next;

   // Associativity is kept as log2(A), clamped to the number of physical banks.
   function automatic logic [1:0] f_log2a(input logic [1:0] sel);
      if (32'(sel) > 32'(WAY_W)) return 2'(WAY_W);
      return sel;
   endfunction

   logic [1:0]        r_mode, r_log2a;
   logic [WAY_W-1:0]  r_rr, r_victim;
   logic              r_evict, r_is_write;
   logic [WA_W-1:0]   r_waddr;
   logic [DATA_W-1:0] r_wdata;

   logic                            w_accept;
   logic [IDX_W-1:0]                w_req_idx, w_idx;
   logic [TAG_W-1:0]                w_tag;
   logic [NUM_WAYS-1:0]             w_bank_we, w_rd_valid, w_cand, w_hit_vec;
   logic [NUM_WAYS-1:0][TAG_W-1:0]  w_rd_tag;
   logic [NUM_WAYS-1:0][DATA_W-1:0] w_rd_data;
   logic [DATA_W-1:0]               w_bank_wdata;
   logic [WAY_W-1:0]                w_grp, w_amask, w_hit_way, w_inv_way, w_victim;
   logic                            w_hit, w_inv_found;
   logic                            w_unused_addr;

   assign w_unused_addr = &{1'b0, i_addr[1:0]};
   assign w_accept  = (r_state == S_IDLE) && (selection_signal == r_mode) && (i_read || i_write);
   assign w_req_idx = i_addr[IDX_W+1:2];
   assign w_idx     = r_waddr[IDX_W-1:0];
   assign w_tag     = r_waddr[WA_W-1:IDX_W];

   // Banks: registered read on accept so the arrays map onto block RAM; valid bits stay in flops
   // so a mode change can clear them in a single cycle.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_WAYS; gi++) begin : g_bank
         logic [TAG_W-1:0]  r_tag_mem  [DEPTH];
         logic [DATA_W-1:0] r_data_mem [DEPTH];
         logic [DEPTH-1:0]  r_valid;
         logic [TAG_W-1:0]  r_rd_tag;
         logic [DATA_W-1:0] r_rd_data;
         logic              r_rd_valid;

         always_ff @(posedge clk) begin
            if (w_bank_we[gi]) begin
               r_tag_mem[w_idx]  <= w_tag;
               r_data_mem[w_idx] <= w_bank_wdata;
            end
            if (w_accept) begin
               r_rd_tag  <= r_tag_mem[w_req_idx];
               r_rd_data <= r_data_mem[w_req_idx];
            end
         end

         always_ff @(posedge clk) begin
            if (reset || r_state == S_FLUSH) begin
               r_valid    <= '0;
               r_rd_valid <= 1'b0;
            end else begin
               if (w_bank_we[gi]) r_valid[w_idx] <= 1'b1;
               if (w_accept)      r_rd_valid     <= r_valid[w_req_idx];
            end
         end

         assign w_rd_tag[gi]   = r_rd_tag;
         assign w_rd_data[gi]  = r_rd_data;
         assign w_rd_valid[gi] = r_rd_valid;
      end
   endgenerate

   // Candidate banks are those whose upper index bits equal the address group field.
   always_comb begin
      w_amask     = ~({WAY_W{1'b1}} << r_log2a);
      w_grp       = r_waddr[IDX_W +: WAY_W] & ({WAY_W{1'b1}} >> r_log2a);
      w_cand      = '0;
      w_hit_vec   = '0;
      w_hit_way   = '0;
      w_inv_way   = '0;
      w_inv_found = 1'b0;
      for (int w = NUM_WAYS - 1; w >= 0; w--) begin
         w_cand[w]    = ((WAY_W'(w) >> r_log2a) == w_grp);
         w_hit_vec[w] = w_cand[w] && w_rd_valid[w] && (w_rd_tag[w] == w_tag);
         if (w_hit_vec[w]) w_hit_way = WAY_W'(w);
         if (w_cand[w] && !w_rd_valid[w]) begin
            w_inv_way   = WAY_W'(w);
            w_inv_found = 1'b1;
         end
      end
      w_hit    = |w_hit_vec;
      w_victim = w_inv_found ? w_inv_way : ((w_grp << r_log2a) | (r_rr & w_amask));
   end

   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_next;
   end

   always_comb begin
      w_state_next     = r_state;
      o_ready          = 1'b0;
      o_readdata       = '0;
      o_readdata_valid = 1'b0;
      hit              = 1'b0;
      miss             = 1'b0;
      mem_req          = 1'b0;
      mem_we           = 1'b0;
      mem_addr         = '0;
      mem_wdata        = '0;
      w_bank_we        = '0;
      w_bank_wdata     = '0;
      case (r_state)
         S_IDLE: begin
            o_ready = 1'b1;
            if (selection_signal != r_mode) w_state_next = S_FLUSH;
            else if (i_read || i_write)     w_state_next = S_COMPARE;
         end
         S_FLUSH: w_state_next = S_IDLE;
         S_COMPARE: begin
            hit  = w_hit;
            miss = !w_hit;
            if (r_is_write) begin
               if (w_hit) begin
                  w_bank_we[w_hit_way] = 1'b1;
                  w_bank_wdata         = r_wdata;
               end
               w_state_next = S_MEM_WR;
            end else if (w_hit) begin
               o_readdata       = w_rd_data[w_hit_way];
               o_readdata_valid = 1'b1;
               w_state_next     = S_IDLE;
            end else begin
               w_state_next = S_MEM_RD;
            end
         end
         S_MEM_RD: begin
            mem_req  = 1'b1;
            mem_addr = {r_waddr, 2'b00};
            if (mem_ack) begin
               w_bank_we[r_victim] = 1'b1;
               w_bank_wdata        = mem_rdata;
               o_readdata          = mem_rdata;
               o_readdata_valid    = 1'b1;
               w_state_next        = S_IDLE;
            end
         end
         S_MEM_WR: begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = {r_waddr, 2'b00};
            mem_wdata = r_wdata;
            if (mem_ack) w_state_next = S_IDLE;
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_mode     <= selection_signal;
         r_log2a    <= f_log2a(selection_signal);
         r_rr       <= '0;
         r_victim   <= '0;
         r_evict    <= 1'b0;
         r_is_write <= 1'b0;
         r_waddr    <= '0;
         r_wdata    <= '0;
      end else begin
         if (w_accept) begin
            r_waddr    <= i_addr[ADDR_W-1:2];
            r_wdata    <= i_writedata;
            r_is_write <= i_write;
         end
         if (r_state == S_FLUSH) begin
            r_mode  <= selection_signal;
            r_log2a <= f_log2a(selection_signal);
            r_rr    <= '0;
         end
         if (r_state == S_COMPARE) begin
            r_victim <= w_victim;
            r_evict  <= !w_inv_found;
         end
         // Pointer only advances when a refill actually displaces a valid line.
         if (r_state == S_MEM_RD && mem_ack && r_evict) r_rr <= r_rr + WAY_W'(1);
      end
   end

`ifdef CACHE_STATS_EN
   logic [31:0] r_hit_count, r_miss_count;
   always_ff @(posedge clk) begin
      if (reset || r_state == S_FLUSH) begin
         r_hit_count  <= '0;
         r_miss_count <= '0;
      end else begin
         if (hit && r_hit_count != 32'hFFFF_FFFF)   r_hit_count  <= r_hit_count + 32'd1;
         if (miss && r_miss_count != 32'hFFFF_FFFF) r_miss_count <= r_miss_count + 32'd1;
      end
   end
   assign hit_count  = r_hit_count;
   assign miss_count = r_miss_count;
`else
   assign hit_count  = '0;
   assign miss_count = '0;
`endif

endmodule

// File: tb/tb_reconfig_cache_ctrl.sv
// Scoreboard bench for reconfig_cache_ctrl: stimulus pushes expectations, a monitor pops and compares.
module tb_reconfig_cache_ctrl;
   logic        clk, reset;
   logic [1:0]  selection_signal;
   logic        i_read, i_write;
   logic [31:0] i_addr, i_writedata;
   logic        o_ready, o_readdata_valid, hit, miss, mem_req, mem_we, mem_ack;
   logic [31:0] o_readdata, mem_addr, mem_wdata, mem_rdata, hit_count, miss_count;

   reconfig_cache_ctrl dut (
      .clk(clk), .reset(reset), .selection_signal(selection_signal),
      .i_read(i_read), .i_write(i_write), .i_addr(i_addr), .i_writedata(i_writedata),
      .o_ready(o_ready), .o_readdata(o_readdata), .o_readdata_valid(o_readdata_valid),
      .hit(hit), .miss(miss), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .hit_count(hit_count), .miss_count(miss_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {logic we; logic [31:0] addr; logic [31:0] wdata;} memx_t;
   typedef struct {string name; logic [31:0] act; logic [31:0] exp;} chk_t;

   logic [1:0]  exp_hm[$];
   logic [31:0] exp_rd[$];
   memx_t       exp_mem[$];
   chk_t        exp_chk[$];

   logic done, tmo, hold_ack, stale_req;
   int   n_vec, n_err;

   function automatic logic [31:0] mem_default(input logic [31:0] a);
      return 32'hDEAD0000 | {16'h0, a[15:0]};
   endfunction

   // Backing memory: acks three cycles after a request is seen, remembers writes.
   logic [31:0] mem_store [logic [31:0]];
   initial begin
      logic busy;
      int   dly;
      busy = 1'b0; dly = 0;
      mem_ack = 1'b0; mem_rdata = '0;
      forever begin
         @(posedge clk); #1;
         mem_ack = 1'b0;
         if (stale_req) begin
            mem_ack   = 1'b1;
            mem_rdata = 32'hBAD0BAD0;
         end else if (reset) begin
            busy = 1'b0;
         end else if (mem_req && !busy) begin
            busy = 1'b1; dly = 2;
         end else if (busy && !hold_ack) begin
            if (dly > 0) dly--;
            else begin
               mem_ack = 1'b1;
               if (mem_we) mem_store[mem_addr] = mem_wdata;
               else mem_rdata = mem_store.exists(mem_addr) ? mem_store[mem_addr] : mem_default(mem_addr);
               busy = 1'b0;
            end
         end
      end
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic unexpected(input string nm);
      n_vec++;
      n_err++;
      $display("FAIL %s: DUT event with no queued expectation", nm);
   endtask

   // Monitor: all comparisons happen here, sampled on the falling edge.
   initial begin
      logic  prev_req;
      int    cyc;
      memx_t em;
      chk_t  c;
      n_vec = 0; n_err = 0; prev_req = 1'b0; cyc = 0;
      forever begin
         @(negedge clk);
         cyc++;
         if (!reset) begin
            if (hit || miss) begin
               if (exp_hm.size() == 0) unexpected("hitmiss");
               else check("hitmiss", {30'd0, hit, miss}, {30'd0, exp_hm.pop_front()});
            end
            if (o_readdata_valid) begin
               if (exp_rd.size() == 0) unexpected("readdata_valid");
               else check("readdata", o_readdata, exp_rd.pop_front());
            end
            if (mem_req && !prev_req) begin
               if (exp_mem.size() == 0) unexpected("mem_req");
               else begin
                  em = exp_mem.pop_front();
                  check("mem_we", {31'd0, mem_we}, {31'd0, em.we});
                  check("mem_addr", mem_addr, em.addr);
                  if (em.we) check("mem_wdata", mem_wdata, em.wdata);
               end
            end
         end
         prev_req = mem_req;
         while (exp_chk.size() > 0) begin
            c = exp_chk.pop_front();
            check(c.name, c.act, c.exp);
         end
         if (done || cyc > 20000) begin
            if (!done) begin
               n_vec++; n_err++;
               $display("FAIL watchdog: got %0d cycles, expected completion", cyc);
            end
            check("hm_queue_left", 32'(exp_hm.size()), 32'd0);
            check("rd_queue_left", 32'(exp_rd.size()), 32'd0);
            check("mem_queue_left", 32'(exp_mem.size()), 32'd0);
            check("timeouts", {31'd0, tmo}, 32'd0);
            $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
            $finish;
         end
      end
   end

   task automatic wait_ready();
      int n = 0;
      while (!o_ready && n < 200) begin @(negedge clk); n++; end
      if (!o_ready) begin
         $display("FAIL ready_timeout: got o_ready=0, expected 1");
         tmo = 1'b1;
      end
   endtask

   task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      wait_ready();
      i_write = wr; i_read = !wr; i_addr = a; i_writedata = d;
      @(posedge clk); #1;
      i_write = 1'b0; i_read = 1'b0;
   endtask

   task automatic rd(input logic [31:0] a, input logic exp_hit, input logic [31:0] exp_d);
      exp_hm.push_back(exp_hit ? 2'b10 : 2'b01);
      if (!exp_hit) exp_mem.push_back('{1'b0, a, 32'h0});
      exp_rd.push_back(exp_d);
      $display("txn read  addr=%h expect %s data=%h", a, exp_hit ? "hit " : "miss", exp_d);
      issue(1'b0, a, 32'h0);
      @(negedge clk);
      wait_ready();
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic exp_hit);
      exp_hm.push_back(exp_hit ? 2'b10 : 2'b01);
      exp_mem.push_back('{1'b1, a, d});
      $display("txn write addr=%h expect %s data=%h", a, exp_hit ? "hit " : "miss", d);
      issue(1'b1, a, d);
      @(negedge clk);
      wait_ready();
   endtask

   task automatic set_mode(input logic [1:0] m);
      int lo = 0;
      @(negedge clk);
      wait_ready();
      selection_signal = m;
      repeat (4) begin
         @(negedge clk);
         if (!o_ready) lo++;
      end
      $display("txn mode  -> %b, ready low for %0d cycle(s)", m, lo);
      exp_chk.push_back('{"flush_ready_low", 32'(lo), 32'd1});
   endtask

   initial begin
      logic [31:0] addrs [4];
      int n;
      addrs[0] = 32'h100; addrs[1] = 32'h500; addrs[2] = 32'h900; addrs[3] = 32'hD00;
      done = 1'b0; tmo = 1'b0; hold_ack = 1'b0; stale_req = 1'b0;
      reset = 1'b1; selection_signal = 2'b00;
      i_read = 1'b0; i_write = 1'b0; i_addr = '0; i_writedata = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      exp_chk.push_back('{"reset_ready", {31'd0, o_ready}, 32'd1});
      exp_chk.push_back('{"reset_mem_req", {31'd0, mem_req}, 32'd0});
      exp_chk.push_back('{"reset_rd_valid", {31'd0, o_readdata_valid}, 32'd0});
      exp_chk.push_back('{"reset_readdata", o_readdata, 32'd0});

      // Direct-mapped: first miss, then hit, then 0x100/0x500 thrash the same set.
      rd(32'h100, 1'b0, 32'hDEAD0100);
      rd(32'h100, 1'b1, 32'hDEAD0100);
      for (int k = 0; k < 4; k++)
         rd((k % 2 == 0) ? 32'h500 : 32'h100, 1'b0, (k % 2 == 0) ? 32'hDEAD0500 : 32'hDEAD0100);

      // 4-way: fill four ways, hit all, then evict way 0 and way 1 in turn.
      set_mode(2'b10);
      for (int k = 0; k < 4; k++) rd(addrs[k], 1'b0, mem_default(addrs[k]));
      for (int k = 0; k < 4; k++) rd(addrs[k], 1'b1, mem_default(addrs[k]));
      rd(32'h1100, 1'b0, 32'hDEAD1100);
      rd(32'h100, 1'b0, 32'hDEAD0100);

      // Write-through on hit, no allocate on miss.
      wr(32'h100, 32'h12345678, 1'b1);
      rd(32'h100, 1'b1, 32'h12345678);
      wr(32'h200, 32'hCAFE0200, 1'b0);
      rd(32'h200, 1'b0, 32'hCAFE0200);

      // Mode change flushes everything.
      set_mode(2'b01);
      rd(32'h100, 1'b0, 32'h12345678);
      rd(32'h100, 1'b1, 32'h12345678);

      // Reset while a refill is outstanding; a late ack must be ignored.
      hold_ack = 1'b1;
      exp_hm.push_back(2'b01);
      exp_mem.push_back('{1'b0, 32'h300, 32'h0});
      $display("txn read  addr=00000300 expect miss, reset while waiting for memory");
      issue(1'b0, 32'h300, 32'h0);
      n = 0;
      while (!mem_req && n < 50) begin @(negedge clk); n++; end
      exp_chk.push_back('{"mem_req_before_reset", {31'd0, mem_req}, 32'd1});
`ifdef CACHE_STATS_EN
      exp_chk.push_back('{"hit_count_pre", hit_count, 32'd1});
      exp_chk.push_back('{"miss_count_pre", miss_count, 32'd2});
`endif
      @(negedge clk); reset = 1'b1;
      @(negedge clk);
      exp_chk.push_back('{"mem_req_after_reset", {31'd0, mem_req}, 32'd0});
      @(negedge clk); reset = 1'b0;
      hold_ack = 1'b0;
      @(negedge clk);
      exp_chk.push_back('{"ready_after_reset", {31'd0, o_ready}, 32'd1});
`ifdef CACHE_STATS_EN
      exp_chk.push_back('{"hit_count_reset", hit_count, 32'd0});
      exp_chk.push_back('{"miss_count_reset", miss_count, 32'd0});
`endif
      stale_req = 1'b1;
      @(negedge clk);
      stale_req = 1'b0;
      repeat (4) @(negedge clk);
      exp_chk.push_back('{"ready_after_stale_ack", {31'd0, o_ready}, 32'd1});
      exp_chk.push_back('{"mem_req_after_stale_ack", {31'd0, mem_req}, 32'd0});
      repeat (3) @(negedge clk);
      done = 1'b1;
   end
endmodule
